// File: rtl/ahb_lite_nm_arbiter_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and arbiter mode constants.
//   HTRANS_* : transfer type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   HRESP_*  : response encodings (OKAY/ERROR)
//   ARB_*    : arbitration mode selectors for ahb_lite_nm_arbiter
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/ahb_lite_nm_arbiter_rr_pick.sv
// arb_rr_pick: combinational N-way circular request picker.
//   req       : request vector, one bit per master
//   start     : index where the upward search begins (0 gives fixed priority)
//   grant     : one-hot winner, all zero when nothing is requesting
//   grant_idx : binary index of the winner (0 when nothing is requesting)
module arb_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    always_comb begin
        int unsigned pos;
        logic        found;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        pos       = 0;
        for (int k = 0; k < N; k++) begin
            pos = (int'(start) + k) % N;
            if (!found && req[pos]) begin
                found      = 1'b1;
                grant[pos] = 1'b1;
                grant_idx  = IDX_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ahb_lite_nm_arbiter.sv
// ahb_lite_nm_arbiter: N-master AHB-Lite arbiter and master multiplexer.
//   HCLK/HRESETn        : bus clock, asynchronous active-low reset
//   m_*                 : packed per-master address/control/write-data inputs
//   m_hready            : per-master HREADY; only the address-phase owner sees HREADY
//   m_hrdata/m_hresp    : broadcast copies of the slave response
//   HADDR..HWDATA       : shared bus towards decoder and slaves
//   HRDATA/HREADY/HRESP : response from the slave mux
//   HMASTER             : current address-phase owner
module ahb_lite_nm_arbiter
    import ahb_pkg::*;
#(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ARB_MODE       = 0,
    parameter int DEFAULT_MASTER = 0
) (
    input  logic                          HCLK,
    input  logic                          HRESETn,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_haddr,
    input  logic [N_MASTERS*2-1:0]        m_htrans,
    input  logic [N_MASTERS-1:0]          m_hwrite,
    input  logic [N_MASTERS*3-1:0]        m_hsize,
    input  logic [N_MASTERS*3-1:0]        m_hburst,
    input  logic [N_MASTERS*4-1:0]        m_hprot,
    input  logic [N_MASTERS-1:0]          m_hmastlock,
    input  logic [N_MASTERS*DATA_W-1:0]   m_hwdata,
    output logic [N_MASTERS-1:0]          m_hready,
    output logic [DATA_W-1:0]             m_hrdata,
    output logic                          m_hresp,
    output logic [ADDR_W-1:0]             HADDR,
    output logic [1:0]                    HTRANS,
    output logic                          HWRITE,
    output logic [2:0]                    HSIZE,
    output logic [2:0]                    HBURST,
    output logic [3:0]                    HPROT,
    output logic                          HMASTLOCK,
    output logic [DATA_W-1:0]             HWDATA,
    input  logic [DATA_W-1:0]             HRDATA,
    input  logic                          HREADY,
    input  logic                          HRESP,
    output logic [$clog2(N_MASTERS)-1:0]  HMASTER
);

    localparam int IDX_W = $clog2(N_MASTERS);
    localparam logic [IDX_W-1:0] DEF_IDX  = IDX_W'(DEFAULT_MASTER);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MASTERS - 1);

    logic [ADDR_W-1:0] haddr_arr  [N_MASTERS];
    logic [1:0]        htrans_arr [N_MASTERS];
    logic [2:0]        hsize_arr  [N_MASTERS];
    logic [2:0]        hburst_arr [N_MASTERS];
    logic [3:0]        hprot_arr  [N_MASTERS];
    logic [DATA_W-1:0] hwdata_arr [N_MASTERS];
    logic [N_MASTERS-1:0] req;

    logic [IDX_W-1:0] owner_reg, owner_next;
    logic [IDX_W-1:0] data_owner_reg, data_owner_next;
    logic [IDX_W-1:0] rr_last_reg, rr_last_next;
    logic [IDX_W-1:0] start_ptr;
    logic [IDX_W-1:0] win_idx;
    logic [N_MASTERS-1:0] win_onehot;
    logic             arb_point;

    // Slice the packed master buses and gate HREADY to the owner only.
    for (genvar gi = 0; gi < N_MASTERS; gi++) begin : g_master
        assign haddr_arr[gi]  = m_haddr[gi*ADDR_W +: ADDR_W];
        assign htrans_arr[gi] = m_htrans[gi*2 +: 2];
        assign hsize_arr[gi]  = m_hsize[gi*3 +: 3];
        assign hburst_arr[gi] = m_hburst[gi*3 +: 3];
        assign hprot_arr[gi]  = m_hprot[gi*4 +: 4];
        assign hwdata_arr[gi] = m_hwdata[gi*DATA_W +: DATA_W];
        assign req[gi]        = (m_htrans[gi*2 +: 2] == HTRANS_NONSEQ);
        // Holding a non-owner's HREADY low freezes it in its address phase.
        assign m_hready[gi]   = (owner_reg == IDX_W'(gi)) ? HREADY : 1'b0;
    end

    assign HADDR     = haddr_arr[owner_reg];
    assign HTRANS    = htrans_arr[owner_reg];
    assign HWRITE    = m_hwrite[owner_reg];
    assign HSIZE     = hsize_arr[owner_reg];
    assign HBURST    = hburst_arr[owner_reg];
    assign HPROT     = hprot_arr[owner_reg];
    assign HMASTLOCK = m_hmastlock[owner_reg];
    assign HWDATA    = hwdata_arr[data_owner_reg];
    assign HMASTER   = owner_reg;
    assign m_hrdata  = HRDATA;
    assign m_hresp   = HRESP;

    // Only an idle, unlocked owner with a completing data phase may be replaced,
    // so bursts, back-to-back transfers and locked sequences are never split.
    assign arb_point = HREADY && (htrans_arr[owner_reg] == HTRANS_IDLE)
                       && !m_hmastlock[owner_reg];

    always_comb begin
        start_ptr = '0;
        if (ARB_MODE == ARB_RR) begin
            start_ptr = (rr_last_reg == LAST_IDX) ? '0 : rr_last_reg + IDX_W'(1);
        end
    end

    arb_rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_pick (
        .req       (req),
        .start     (start_ptr),
        .grant     (win_onehot),
        .grant_idx (win_idx)
    );

    always_comb begin
        owner_next      = owner_reg;
        rr_last_next    = rr_last_reg;
        data_owner_next = data_owner_reg;
        if (HREADY) begin
            data_owner_next = owner_reg;
        end
        // With no requester the bus parks on the current owner.
        if (arb_point && (|win_onehot)) begin
            owner_next = win_idx;
            if (win_idx != owner_reg) begin
                rr_last_next = win_idx;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            owner_reg      <= DEF_IDX;
            data_owner_reg <= DEF_IDX;
            rr_last_reg    <= DEF_IDX;
        end else begin
            owner_reg      <= owner_next;
            data_owner_reg <= data_owner_next;
            rr_last_reg    <= rr_last_next;
        end
    end

endmodule

// File: tb/tb_ahb_lite_nm_arbiter.sv
// Testbench for ahb_lite_nm_arbiter: a fixed-priority and a round-robin
// instance (N=3) share the same master/slave stimulus.
module tb_ahb_lite_nm_arbiter;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    logic [N*AW-1:0] m_haddr;
    logic [N*2-1:0]  m_htrans;
    logic [N-1:0]    m_hwrite;
    logic [N*3-1:0]  m_hsize;
    logic [N*3-1:0]  m_hburst;
    logic [N*4-1:0]  m_hprot;
    logic [N-1:0]    m_hmastlock;
    logic [N*DW-1:0] m_hwdata;
    logic [DW-1:0]   HRDATA;
    logic            HREADY;
    logic            HRESP;

    logic [N-1:0]  f_m_hready, r_m_hready;
    logic [DW-1:0] f_m_hrdata, r_m_hrdata;
    logic          f_m_hresp, r_m_hresp;
    logic [AW-1:0] f_haddr, r_haddr;
    logic [1:0]    f_htrans, r_htrans;
    logic          f_hwrite, r_hwrite;
    logic [2:0]    f_hsize, r_hsize, f_hburst, r_hburst;
    logic [3:0]    f_hprot, r_hprot;
    logic          f_hmastlock, r_hmastlock;
    logic [DW-1:0] f_hwdata, r_hwdata;
    logic [1:0]    f_hmaster, r_hmaster;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state: owner, data owner and last grant per mode.
    int mf_own, mf_dn, mf_last;
    int mr_own, mr_dn, mr_last;

    always #5 HCLK = ~HCLK;

    ahb_lite_nm_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
                          .ARB_MODE(0), .DEFAULT_MASTER(0)) u_fix (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hprot(m_hprot),
        .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
        .m_hready(f_m_hready), .m_hrdata(f_m_hrdata), .m_hresp(f_m_hresp),
        .HADDR(f_haddr), .HTRANS(f_htrans), .HWRITE(f_hwrite), .HSIZE(f_hsize),
        .HBURST(f_hburst), .HPROT(f_hprot), .HMASTLOCK(f_hmastlock),
        .HWDATA(f_hwdata), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .HMASTER(f_hmaster)
    );

    ahb_lite_nm_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW),
                          .ARB_MODE(1), .DEFAULT_MASTER(0)) u_rr (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .m_haddr(m_haddr), .m_htrans(m_htrans), .m_hwrite(m_hwrite),
        .m_hsize(m_hsize), .m_hburst(m_hburst), .m_hprot(m_hprot),
        .m_hmastlock(m_hmastlock), .m_hwdata(m_hwdata),
        .m_hready(r_m_hready), .m_hrdata(r_m_hrdata), .m_hresp(r_m_hresp),
        .HADDR(r_haddr), .HTRANS(r_htrans), .HWRITE(r_hwrite), .HSIZE(r_hsize),
        .HBURST(r_hburst), .HPROT(r_hprot), .HMASTLOCK(r_hmastlock),
        .HWDATA(r_hwdata), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .HMASTER(r_hmaster)
    );

    task automatic set_idle();
        m_haddr = '0; m_htrans = '0; m_hwrite = '0; m_hsize = '0;
        m_hburst = '0; m_hprot = '0; m_hmastlock = '0; m_hwdata = '0;
        HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        set_idle();
        @(negedge HCLK);
        HRESETn = 1'b1;
        cyc();
        mf_own = 0; mf_dn = 0; mf_last = 0;
        mr_own = 0; mr_dn = 0; mr_last = 0;
    endtask

    // Reference rules: request = NONSEQ; arbitrate only when HREADY, owner IDLE
    // and owner unlocked; fixed = lowest requester, RR = first above last grant.
    task automatic model_step(input int mode, inout int own, inout int dn, inout int last);
        int win;
        bit ap;
        win = -1;
        ap = HREADY && (m_htrans[own*2 +: 2] == 2'b00) && !m_hmastlock[own];
        for (int k = 0; k < N; k++) begin
            int i;
            i = (mode == 0) ? k : (last + 1 + k) % N;
            if (win < 0 && m_htrans[i*2 +: 2] == 2'b10) win = i;
        end
        if (HREADY) dn = own;
        if (ap && win >= 0) begin
            if (win != own) last = win;
            own = win;
        end
    endtask

    function automatic logic [82:0] bus_expect(input int own, input int dn);
        logic [2:0] rdy;
        rdy = HREADY ? 3'(1 << own) : 3'b000;
        return {m_haddr[own*AW +: AW], m_htrans[own*2 +: 2], m_hwrite[own],
                m_hsize[own*3 +: 3], m_hburst[own*3 +: 3], m_hprot[own*4 +: 4],
                m_hmastlock[own], m_hwdata[dn*DW +: DW], 2'(own), rdy};
    endfunction

    task automatic test_reset();
        @(negedge HCLK);
        HRESETn = 1'b0;
        set_idle();
        #1;
        n_checks++;
        if (f_hmaster !== 2'd0 || f_htrans !== 2'b00 || f_m_hready !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_fix: hmaster=%0d htrans=%b m_hready=%b, required 0 00 001",
                     f_hmaster, f_htrans, f_m_hready);
        end
        n_checks++;
        if (r_hmaster !== 2'd0 || r_htrans !== 2'b00 || r_m_hready !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_rr: hmaster=%0d htrans=%b m_hready=%b, required 0 00 001",
                     r_hmaster, r_htrans, r_m_hready);
        end
        $display("reset: hmaster=%0d m_hready=%b", f_hmaster, f_m_hready);
        do_reset();
    endtask

    task automatic test_handover();
        do_reset();
        m_htrans[5:4] = 2'b10;
        m_haddr[95:64] = 32'h2000_0010;
        m_hwrite[2] = 1'b1;
        m_hwdata = {32'hCAFE_0002, 32'h1111_0001, 32'h0000_0000};
        #1;
        n_checks++;
        if (f_hmaster !== 2'd0 || f_m_hready[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL handover_wait: hmaster=%0d m_hready2=%b, required 0 0", f_hmaster, f_m_hready[2]);
        end
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd2 || f_haddr !== 32'h2000_0010 || f_hwrite !== 1'b1 || f_m_hready[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL handover_grant: hmaster=%0d haddr=%h hwrite=%b rdy2=%b, required 2 20000010 1 1",
                     f_hmaster, f_haddr, f_hwrite, f_m_hready[2]);
        end
        m_htrans[5:4] = 2'b00;
        cyc();
        n_checks++;
        if (f_hwdata !== 32'hCAFE_0002 || f_hmaster !== 2'd2) begin
            n_fail++;
            $display("FAIL handover_wdata: hwdata=%h hmaster=%0d, required cafe0002 2", f_hwdata, f_hmaster);
        end
        $display("handover: hmaster=%0d hwdata=%h", f_hmaster, f_hwdata);
    endtask

    task automatic test_async_reset();
        // Continues from test_handover: M2 owns bus and data phase.
        @(posedge HCLK);
        #3;
        HRESETn = 1'b0;
        #1;
        n_checks++;
        if (f_hmaster !== 2'd0 || f_hwdata !== 32'h0000_0000 || r_hmaster !== 2'd0) begin
            n_fail++;
            $display("FAIL async_reset: f_hmaster=%0d hwdata=%h r_hmaster=%0d, required 0 00000000 0",
                     f_hmaster, f_hwdata, r_hmaster);
        end
        $display("async_reset: hmaster=%0d", f_hmaster);
        do_reset();
    endtask

    task automatic test_fixed_simul();
        do_reset();
        m_htrans = 6'b10_10_00;
        m_haddr = {32'hA200_0000, 32'hA100_0000, 32'h0};
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd1 || f_haddr !== 32'hA100_0000) begin
            n_fail++;
            $display("FAIL fixed_first: hmaster=%0d haddr=%h, required 1 a1000000", f_hmaster, f_haddr);
        end
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd1) begin
            n_fail++;
            $display("FAIL fixed_nosplit: hmaster=%0d, required 1", f_hmaster);
        end
        m_htrans[3:2] = 2'b00;
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd2 || f_haddr !== 32'hA200_0000) begin
            n_fail++;
            $display("FAIL fixed_second: hmaster=%0d haddr=%h, required 2 a2000000", f_hmaster, f_haddr);
        end
        $display("fixed_simul: hmaster=%0d", f_hmaster);
    endtask

    task automatic test_rr_sequence();
        int exp_seq[6] = '{1, 2, 0, 1, 2, 0};
        int own;
        do_reset();
        own = 0;
        for (int k = 0; k < 6; k++) begin
            m_htrans = 6'b10_10_10;
            m_htrans[own*2 +: 2] = 2'b00;
            cyc();
            n_checks++;
            if (r_hmaster !== 2'(exp_seq[k])) begin
                n_fail++;
                $display("FAIL rr_grant%0d: hmaster=%0d, required %0d", k, r_hmaster, exp_seq[k]);
            end
            $display("rr_grant%0d: hmaster=%0d", k, r_hmaster);
            own = exp_seq[k];
            m_htrans = 6'b10_10_10;
            cyc();
        end
    endtask

    task automatic test_lock();
        do_reset();
        m_htrans[3:2] = 2'b10;
        m_hmastlock[1] = 1'b1;
        cyc();
        m_htrans[1:0] = 2'b10;
        m_htrans[3:2] = 2'b00;
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd1) begin
            n_fail++;
            $display("FAIL lock_idle: hmaster=%0d, required 1", f_hmaster);
        end
        m_htrans[3:2] = 2'b10;
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd1) begin
            n_fail++;
            $display("FAIL lock_nonseq: hmaster=%0d, required 1", f_hmaster);
        end
        m_htrans[3:2] = 2'b00;
        m_hmastlock[1] = 1'b0;
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd0) begin
            n_fail++;
            $display("FAIL lock_release: hmaster=%0d, required 0", f_hmaster);
        end
        $display("lock: hmaster=%0d", f_hmaster);
    endtask

    task automatic test_hready_stall();
        do_reset();
        m_htrans[3:2] = 2'b10;
        HREADY = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if (f_hmaster !== 2'd0 || f_m_hready !== 3'b000) begin
                n_fail++;
                $display("FAIL stall%0d: hmaster=%0d m_hready=%b, required 0 000", k, f_hmaster, f_m_hready);
            end
        end
        HREADY = 1'b1;
        cyc();
        n_checks++;
        if (f_hmaster !== 2'd1 || f_m_hready !== 3'b010) begin
            n_fail++;
            $display("FAIL stall_release: hmaster=%0d m_hready=%b, required 1 010", f_hmaster, f_m_hready);
        end
        $display("hready_stall: hmaster=%0d", f_hmaster);
    endtask

    task automatic test_random();
        logic [82:0] got, exp;
        int bad;
        do_reset();
        bad = 0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                int r;
                r = $urandom_range(0, 7);
                m_htrans[i*2 +: 2] = (r < 4) ? 2'b00 : (r < 6) ? 2'b10 : (r == 6) ? 2'b11 : 2'b01;
                m_hmastlock[i] = ($urandom_range(0, 7) == 0);
            end
            m_haddr = {$urandom, $urandom, $urandom};
            m_hwdata = {$urandom, $urandom, $urandom};
            m_hwrite = 3'($urandom);
            m_hsize = 9'($urandom);
            m_hburst = 9'($urandom);
            m_hprot = 12'($urandom);
            HRDATA = $urandom;
            HREADY = ($urandom_range(0, 3) != 0);
            HRESP = ($urandom_range(0, 7) == 0);
            #1;
            got = {f_haddr, f_htrans, f_hwrite, f_hsize, f_hburst, f_hprot,
                   f_hmastlock, f_hwdata, f_hmaster, f_m_hready};
            exp = bus_expect(mf_own, mf_dn);
            n_checks++;
            if (got !== exp) begin
                n_fail++; bad++;
                $display("FAIL rand_fix cyc%0d: got %h, required %h", c, got, exp);
            end
            got = {r_haddr, r_htrans, r_hwrite, r_hsize, r_hburst, r_hprot,
                   r_hmastlock, r_hwdata, r_hmaster, r_m_hready};
            exp = bus_expect(mr_own, mr_dn);
            n_checks++;
            if (got !== exp) begin
                n_fail++; bad++;
                $display("FAIL rand_rr cyc%0d: got %h, required %h", c, got, exp);
            end
            n_checks++;
            if (f_m_hrdata !== HRDATA || f_m_hresp !== HRESP || r_m_hrdata !== HRDATA || r_m_hresp !== HRESP) begin
                n_fail++; bad++;
                $display("FAIL rand_resp cyc%0d: hrdata=%h/%h hresp=%b/%b, required %h %b",
                         c, f_m_hrdata, r_m_hrdata, f_m_hresp, r_m_hresp, HRDATA, HRESP);
            end
            model_step(0, mf_own, mf_dn, mf_last);
            model_step(1, mr_own, mr_dn, mr_last);
            cyc();
        end
        $display("random: 400 cycles, %0d mismatching cycles", bad);
    endtask

    initial begin
        set_idle();
        test_reset();
        test_handover();
        test_async_reset();
        test_fixed_simul();
        test_rr_sequence();
        test_lock();
        test_hready_stall();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_lite_nm_arbiter.md
# ahb_lite_nm_arbiter

Parametrised N-master AHB-Lite arbiter and master multiplexer. It replaces the fixed two-master CPU/DMA arbiter and the hand-written master mux in `my_soc`. It selects one address-phase owner at a time and drives the shared AHB bus seen by the decoder and slaves. It tracks the data-phase owner for HWDATA routing, and stalls non-owning masters through per-master HREADY.

## Interface
- `N_MASTERS`, 2: number of master ports (2..8).
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `ARB_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `DEFAULT_MASTER`, 0: owner after reset.

Ports:
- `HCLK` in 1: bus clock.
- `HRESETn` in 1: reset. One clock (HCLK); reset is asynchronous and active-low (HRESETn).
- `m_haddr` in N_MASTERS*ADDR_W: packed master addresses; master i occupies slice i.
- `m_htrans` in N_MASTERS*2: packed master HTRANS.
- `m_hwrite` in N_MASTERS: per-master HWRITE.
- `m_hsize` in N_MASTERS*3: per-master HSIZE.
- `m_hburst` in N_MASTERS*3: per-master HBURST.
- `m_hprot` in N_MASTERS*4: per-master HPROT.
- `m_hmastlock` in N_MASTERS: per-master HMASTLOCK.
- `m_hwdata` in N_MASTERS*DATA_W: per-master write data.
- `m_hready` out N_MASTERS: per-master HREADY.
- `m_hrdata` out DATA_W: broadcast copy of HRDATA.
- `m_hresp` out 1: broadcast copy of HRESP.
- `HADDR` out ADDR_W, `HTRANS` out 2, `HWRITE` out 1, `HSIZE` out 3, `HBURST` out 3, `HPROT` out 4, `HMASTLOCK` out 1, `HWDATA` out DATA_W: shared bus.
- `HRDATA` in DATA_W, `HREADY` in 1, `HRESP` in 1: from slave mux.
- `HMASTER` out $clog2(N_MASTERS): current address-phase owner.

## Operation
- Request: master i requests when `m_htrans[i]` = NONSEQ.
- Registers:
  - `owner`: address-phase owner.
  - `data_owner`: data-phase owner.
  - `rr_last`: last granted index (round-robin only).
- Address mux: HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT and HMASTLOCK come combinationally from master `owner`.
- HWDATA mux: HWDATA comes from master `data_owner`.
- HREADY routing:
  - `m_hready[owner]` = HREADY.
  - Every other `m_hready[i]` = 0, which holds non-owners in their address phase (legal for IDLE or NONSEQ).
- Read response: HRDATA and HRESP are broadcast to all masters unchanged.
- Arbitration point: HREADY=1, owner's HTRANS=IDLE and owner's HMASTLOCK=0, all in the same cycle.
  - At that edge, `owner` takes the winner among requesters.
  - With no requester, `owner` is unchanged (park on last owner).
- Winner selection:
  - Fixed mode: lowest requesting index.
  - Round-robin mode: first requester searching upward from rr_last+1 modulo N_MASTERS. `rr_last` updates to the winner only when the owner actually changes.
- Owner issuing NONSEQ/SEQ/BUSY is never an arbitration point, so bursts and back-to-back transfers are never split. Fairness requires masters to insert IDLE.
- HMASTLOCK=1 from the owner blocks arbitration even during IDLE cycles.
- `data_owner` is loaded with `owner` on every edge where HREADY=1.

## Timing
- Reset values: `owner`, `data_owner` and `rr_last` = DEFAULT_MASTER; HMASTER = DEFAULT_MASTER.
- Bus outputs after reset: combinational copies of the default master's inputs. `m_hready[DEFAULT_MASTER]` = HREADY; all other `m_hready` = 0.
- Owner path: an owner's NONSEQ reaches the bus in the same cycle (0 added latency).
- Handover: a non-owner's NONSEQ, raised in a cycle that is an arbitration point and wins, appears on HADDR the cycle after. Its `m_hready` is low for exactly that one cycle.
- If HREADY=0 in the arbitration cycle (old IDLE data phase stretched or ERROR first cycle), the handover waits until HREADY=1.
- ERROR response: the 2-cycle response goes only to the owner's `m_hready`. Arbitration follows the normal rule.
- Simultaneous requests resolve by ARB_MODE in the same cycle.
- Reset asserted mid-transfer: all registers return to reset values immediately, with no transfer completion.

## Structure
- Shared package `ahb_pkg`: HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP encodings, ARB_MODE constants.
- One sub-module `arb_rr_pick`: combinational N-way request vector plus start pointer in, one-hot and index out. Fixed mode uses start pointer 0.
- Top: registers, muxes and HREADY gating.

## Test plan
- Reset, N=3, all IDLE: HMASTER=0, HTRANS=IDLE, `m_hready`=3'b001 with HREADY=1.
- Owner 0 IDLE, M2 NONSEQ write 0x2000_0010: next cycle HMASTER=2 and HADDR=0x2000_0010. `m_hready[2]` low one cycle. HWDATA equals `m_hwdata[2]` in the following data phase.
- Fixed mode, M1 and M2 NONSEQ in the same cycle: M1 granted first. M2 granted on the edge after M1 drives IDLE.
- Round-robin, M0/M1/M2 each issue single NONSEQ then IDLE, repeatedly: grant sequence 1,2,0,1,2,0.
- M1 owner with HMASTLOCK=1 and an IDLE cycle inside the locked sequence, M0 requesting: no switch until M1 drops HMASTLOCK with IDLE, then HMASTER=0 on the next cycle.
- Slave holds HREADY=0 for 3 cycles during an arbitration cycle with M1 requesting: HMASTER unchanged for those 3 cycles, switches to 1 the cycle after HREADY rises.
